counter_sequencer: RTL and testbench
====================================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: CNT_W, default 4, counter and length width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a counting run; sampled only in IDLE.
REQ-005 length  input  CNT_W  number of enabled count cycles; 0 encodes 2^CNT_W.
REQ-006 pause  input  1  hold the count while in RUN.
REQ-007 abort  input  1  terminate the run without a done pulse.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 counter_out  output  CNT_W  live value of the internal counter.
REQ-011 mismatch  output  1  sticky: counter_out differed from the shadow count.

Function
REQ-012 FSM states SHALL be IDLE, CLEAR, RUN and DONE.
REQ-013 IDLE -> CLEAR on an edge sampling start=1 and abort=0; length is latched into remaining_q on that edge and mismatch is cleared.
REQ-014 CLEAR SHALL assert the counter clear for exactly one cycle; at the next edge counter_out=0, shadow=0 and state=RUN, or IDLE if abort=1.
REQ-015 RUN: counter enable = ~pause & ~abort; each enabled edge increments counter and shadow modulo 2^CNT_W and decrements remaining_q.
REQ-016 RUN -> DONE on the enabled edge that takes remaining_q from 1 to 0; a latched 0 means 2^CNT_W enabled edges, ending with counter_out=0 after wrap.
REQ-017 DONE lasts exactly one cycle with done=1, enable=0 and pause/start/abort ignored, then IDLE.
REQ-018 With no pause, the run is busy for N+2 cycles (CLEAR, N RUN, DONE), and counter_out=N mod 2^CNT_W during DONE.
REQ-019 abort=1 in CLEAR or RUN -> IDLE at the next edge; counter is neither cleared nor incremented that edge, and done stays 0.
REQ-020 abort has priority over pause; pause has priority over counting; start while busy is ignored.
REQ-021 counter_out SHALL hold its last value in IDLE until the next CLEAR or reset.
REQ-022 In RUN and DONE, counter_out != shadow at a rising edge SHALL set mismatch; mismatch stays set until the next accepted start or reset.

Reset
REQ-023 reset=1 at an edge SHALL force state=IDLE, counter_out=0, shadow=0, remaining_q=0, busy=0, done=0 and mismatch=0, overriding all other inputs, including mid-run.
REQ-024 The counter's reset input SHALL be the OR of reset and the CLEAR-state clear strobe.

Structure
REQ-025 Package counter_seq_pkg SHALL hold the CNT_W default and the 2-bit state encodings IDLE=0, CLEAR=1, RUN=2, DONE=3.
REQ-026 Exactly one sub-module: first_counter (ports clk, reset, enable, counter_out; synchronous clear, increment on enable, wraps) as the counting datapath; the FSM, shadow counter and remaining_q live in counter_sequencer.

Verification
REQ-027 reset 2 cycles; start, length=5, pause=0 -> busy 7 cycles; counter 0,1..5; done one cycle with counter_out=5; mismatch=0.
REQ-028 start, length=0 -> 16 enabled edges; counter wraps 15->0; done with counter_out=0 after 18 busy cycles.
REQ-029 start, length=4; pause=1 for 3 cycles after counter reaches 2 -> counter holds 2 for 3 cycles; done at 4; busy 9 cycles.
REQ-030 start, length=10; abort when counter=3 -> IDLE next edge; counter_out holds 3; done never asserted.
REQ-031 start while busy, and start with abort=1 in IDLE -> both ignored; reset mid-run -> next edge busy=0, counter_out=0.
REQ-032 Force first_counter enable low for one RUN cycle -> mismatch=1 next edge and stays set until the next start.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared width default and state encodings for the counter sequencer.
package counter_seq_pkg;

   localparam int unsigned CNT_W_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/first_counter.sv
// Wrapping up-counter with synchronous clear; the sequencer's counting datapath.
module first_counter #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [CNT_W-1:0] counter_out
);

   always_ff @(posedge clk) begin
      if (reset) begin
         counter_out <= '0;
      end else if (enable) begin
         counter_out <= counter_out + CNT_W'(1);
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Runs first_counter for a latched number of enabled cycles, cross-checked by a shadow count.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] length,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] counter_out,
   output logic             mismatch
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             mismatch_q, mismatch_d;
   logic             run_en, clear;
   logic             cnt_en, cnt_reset;

   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      remaining_d = remaining_q;
      mismatch_d  = mismatch_q;
      run_en      = 1'b0;
      clear       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d     = ST_CLEAR;
               remaining_d = length;
               mismatch_d  = 1'b0;
            end
         end
         ST_CLEAR: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               clear    = 1'b1;
               shadow_d = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!pause) begin
               run_en      = 1'b1;
               shadow_d    = shadow_q + CNT_W'(1);
               // A latched 0 wraps through all ones, giving 2^CNT_W enabled edges.
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if ((state_q == ST_RUN || state_q == ST_DONE) && counter_out != shadow_q) begin
         mismatch_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         remaining_q <= '0;
         mismatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         remaining_q <= remaining_d;
         mismatch_q  <= mismatch_d;
      end
   end

   assign cnt_en    = run_en;
   assign cnt_reset = reset | clear;

   first_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk         (clk),
      .reset       (cnt_reset),
      .enable      (cnt_en),
      .counter_out (counter_out)
   );

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: per-cycle model comparison plus literal expectations.
module tb_counter_sequencer;

   localparam int W = 4;
   localparam int M = 16;
   localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DONE = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1, start = 1'b0, pause = 1'b0, abort = 1'b0;
   logic [W-1:0] length = '0;
   logic         busy, done, mismatch;
   logic [W-1:0] counter_out;

   int checks = 0;
   int errors = 0;
   bit force_low = 1'b0;
   int busy_cycles = 0, done_count = 0, done_cnt = 0;

   always #5 clk = ~clk;

   counter_sequencer #(
      .CNT_W (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .length      (length),
      .pause       (pause),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .counter_out (counter_out),
      .mismatch    (mismatch)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase, live count, shadow count and enabled edges still owed (1..16).
   int m_phase = P_IDLE, m_cnt = 0, m_shadow = 0, m_left = 0;
   bit m_mm = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = P_IDLE; m_cnt = 0; m_shadow = 0; m_left = 0; m_mm = 1'b0;
      end else begin
         if ((m_phase == P_RUN || m_phase == P_DONE) && m_cnt != m_shadow) m_mm = 1'b1;
         case (m_phase)
            P_IDLE: if (start && !abort) begin
               m_phase = P_CLEAR;
               m_left  = (length == 0) ? M : int'(length);
               m_mm    = 1'b0;
            end
            P_CLEAR: if (abort) m_phase = P_IDLE;
               else begin m_cnt = 0; m_shadow = 0; m_phase = P_RUN; end
            P_RUN: if (abort) m_phase = P_IDLE;
               else if (!pause) begin
                  m_shadow = (m_shadow + 1) % M;
                  if (!force_low) m_cnt = (m_cnt + 1) % M;
                  m_left--;
                  if (m_left == 0) m_phase = P_DONE;
               end
            default: m_phase = P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      check("busy", busy, (m_phase != P_IDLE));
      check("done", done, (m_phase == P_DONE));
      check("counter_out", counter_out, m_cnt);
      check("mismatch", mismatch, m_mm);
      if (busy) busy_cycles++;
      if (done) begin done_count++; done_cnt = counter_out; end
   end

   task automatic drive_start(input int len);
      @(negedge clk); #1;
      start = 1'b1; length = W'(len);
      busy_cycles = 0; done_count = 0; done_cnt = -1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin @(negedge clk); #1; n++; end
      check("wait_idle", busy, 0);
   endtask

   task automatic wait_cnt(input int v, input int bound);
      int n = 0;
      while (counter_out != W'(v) && n < bound) begin @(negedge clk); #1; n++; end
      check("wait_cnt", counter_out, v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", counter_out, 0);
      check("rst_mm", mismatch, 0);
      reset = 1'b0;

      // length 5
      drive_start(5); wait_idle(30);
      check("len5_busy", busy_cycles, 7);
      check("len5_donecnt", done_count, 1);
      check("len5_doneval", done_cnt, 5);
      check("len5_mm", mismatch, 0);

      // length 0 means 16
      drive_start(0); wait_idle(40);
      check("len0_busy", busy_cycles, 18);
      check("len0_donecnt", done_count, 1);
      check("len0_doneval", done_cnt, 0);

      // pause for 3 cycles at count 2
      drive_start(4); wait_cnt(2, 20);
      pause = 1'b1;
      repeat (3) begin @(negedge clk); #1; check("pause_hold", counter_out, 2); end
      pause = 1'b0;
      wait_idle(20);
      check("pause_busy", busy_cycles, 9);
      check("pause_doneval", done_cnt, 4);

      // abort at count 3
      drive_start(10); wait_cnt(3, 20);
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_cnt", counter_out, 3);
      repeat (2) @(negedge clk);
      #1;
      check("abort_hold", counter_out, 3);
      check("abort_nodone", done_count, 0);

      // start while busy is ignored
      drive_start(3);
      @(negedge clk); #1; start = 1'b1; length = 4'd7;
      @(negedge clk); #1; start = 1'b0;
      wait_idle(20);
      check("rebusy_busy", busy_cycles, 5);
      check("rebusy_doneval", done_cnt, 3);
      check("rebusy_donecnt", done_count, 1);

      // start with abort in IDLE is ignored
      @(negedge clk); #1; start = 1'b1; abort = 1'b1;
      @(negedge clk); #1; start = 1'b0; abort = 1'b0;
      check("startabort_busy", busy, 0);
      check("startabort_cnt", counter_out, 3);

      // reset mid-run
      drive_start(6);
      repeat (2) @(negedge clk);
      #1; reset = 1'b1;
      @(negedge clk); #1;
      check("midrst_busy", busy, 0);
      check("midrst_cnt", counter_out, 0);
      reset = 1'b0;

      // counter enable suppressed for one RUN cycle
      drive_start(6); wait_cnt(2, 20);
      force dut.cnt_en = 1'b0;
      force_low = 1'b1;
      @(negedge clk); #1;
      release dut.cnt_en;
      force_low = 1'b0;
      check("force_hold", counter_out, 2);
      @(negedge clk); #1;
      check("force_mm_set", mismatch, 1);
      wait_idle(20);
      check("force_mm_sticky", mismatch, 1);
      check("force_doneval", done_cnt, 5);
      drive_start(2);
      check("force_mm_clear", mismatch, 0);
      wait_idle(20);
      check("final_doneval", done_cnt, 2);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
